uva_nibble_checker: RTL and testbench
=====================================

// Module: uva_nibble_checker
// PURPOSE
//  Receive-side check stage directly downstream of the nibble transmitter. Runs on the 25 MHz domain.
//  Inputs: the 4-bit parallel data stream (TRAN_DATA) and the frame sync strobe.
//  Reassembles nibbles MSB-first into 16-bit words and checks each frame against an incrementing pattern:
//  word0 = seed, word k = seed + k.
//  Reports per-word data, frame pass/fail and saturating statistics counters for the check unit.
// PARAMETERS
//  WORD_NIBS    4   nibbles per word; word width = 4*WORD_NIBS
//  FRAME_WORDS  16  words per frame, including the seed word; must be >= 2
//  CNT_W        16  width of the word, error and frame counters
// PORTS
//  clk_25Mz     in   1         nibble clock; only clock of the block
//  rst_n        in   1         asynchronous active-low reset
//  sinhr        in   1         frame sync; high in the cycle carrying nibble 0 of word 0
//  rx_nibble    in   4         nibble stream from transmitter; bit3 = oldest serial bit
//  clr_cnt      in   1         synchronous clear of all statistics counters
//  word_valid   out  1         1-cycle pulse: word_data holds a complete word
//  word_data    out  16        assembled word, first nibble in [15:12]
//  word_err     out  1         qualifies word_valid: word != expected (never set on the seed word)
//  frame_done   out  1         1-cycle pulse, coincident with word_valid of the last word
//  frame_ok     out  1         valid with frame_done: no word error in the frame
//  frame_abort  out  1         1-cycle pulse: sinhr arrived mid-frame
//  locked       out  1         high from the first sinhr until reset; frame activity seen
//  word_cnt     out  CNT_W     checked words, seed words excluded; saturating
//  err_cnt      out  CNT_W     mismatching words; saturating
//  frame_cnt    out  CNT_W     completed frames, pass or fail; saturating
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; nibble index = 0; internal expected value = 0.
//  FSM states:
//   IDLE   ignores rx_nibble. On sinhr -> SEED, capturing the nibble in that cycle as nibble 0.
//   SEED   collects word 0. On its 4th nibble: expected <= word + 1 -> CHECK.
//          word_valid=1 and word_err=0 in the next cycle.
//   CHECK  on each 4th nibble: compare with expected; expected <= expected + 1, mod 2^16 wrap (0xFFFF -> 0x0000 is legal).
//          After word FRAME_WORDS-1 -> IDLE.
//  Latency: word_valid, word_data, word_err and frame_done are registered.
//   They are asserted the cycle after the 4th nibble is sampled.
//  Nibble index: 2-bit counter, reset to 0 by sinhr, wraps 3 -> 0 at each word boundary.
//  sinhr in SEED or CHECK (mid-frame):
//   - discard the partial word; frame_abort pulses next cycle; frame_cnt is not incremented;
//   - restart in SEED with the current nibble as nibble 0.
//  sinhr on the same cycle as the last nibble of a frame:
//   - the last word completes normally (frame_done pulses);
//   - the nibble is still taken as nibble 0 of the next frame; no abort.
//  frame_ok = 1 iff no word_err occurred since the last SEED entry; sampled only with frame_done.
//  Counters: increment by 1 per event and hold at 2^CNT_W-1.
//  clr_cnt has priority over any increment in the same cycle; that event is not counted.
//  clr_cnt does not affect the FSM or the word outputs.
//  Reset mid-frame: immediate return to the reset state. locked drops; the next sinhr is needed to resume.
// STRUCTURE
//  Package uva_check_pkg:
//   - state_t enum {IDLE, SEED, CHECK}
//   - NIB_W = 4
//   - a function to saturate-increment a CNT_W value
//  Sub-module uva_nibble_assembler:
//   - 4-bit shift-in of nibbles into the word register, plus the nibble index;
//   - outputs word_full for one cycle on the 4th nibble; clear input driven by sinhr.
//  Top: FSM, expected-value register, compare, frame error flag, three counters.
// TESTING
//  1 Reset, sinhr with seed 0x1234, then 15 words 0x1235..0x1243
//    -> 16 word_valid, err=0, frame_done+frame_ok on word 16; word_cnt=15, frame_cnt=1.
//  2 As 1, but word 5 sent as 0xDEAD
//    -> word_err on that word only; frame_ok=0; err_cnt=1; the next word 0x123A still passes (expected continues).
//  3 Seed 0xFFFE
//    -> words 0xFFFF, 0x0000, 0x0001 pass (wrap); err_cnt=0.
//  4 sinhr after 2 nibbles of word 7
//    -> frame_abort pulse; frame_cnt unchanged; the new frame seeded from the following 4 nibbles checks clean.
//  5 Preload err_cnt to 0xFFFF via 65535 bad words, then more errors
//    -> holds 0xFFFF; clr_cnt coincident with an error -> err_cnt=0.
//  6 rst_n low for 1 cycle during word 3
//    -> all outputs 0 at once; nibbles ignored until the next sinhr; locked=0 until then.

Source files
------------

// File: rtl/uva_check_pkg.sv
// ---------------------------------------------------------------------------
// uva_check_pkg
// Shared types and helpers for the nibble checker slice.
//   state_t  : frame checker FSM states
//   NIB_W    : width of one received nibble
//   sat_inc  : saturating increment for statistics counters up to 32 bits
// ---------------------------------------------------------------------------
package uva_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Counters narrower than 32 bits are zero-extended by the caller; the
  // result saturates at 2^width-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/uva_nibble_checker_if.sv
// ---------------------------------------------------------------------------
// uva_nibble_checker_if
// Nibble stream in, per-word / per-frame check results out.
//   sinhr, rx_nibble            : from the transmitter side (master)
//   word_valid/data/err         : per-word result from the checker (slave)
//   frame_done/ok/abort         : per-frame result from the checker (slave)
// ---------------------------------------------------------------------------
interface uva_nibble_checker_if #(
  parameter int WORD_W = 16
);
  import uva_check_pkg::*;

  logic              sinhr;
  logic [NIB_W-1:0]  rx_nibble;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_err;
  logic              frame_done;
  logic              frame_ok;
  logic              frame_abort;

  modport master (
    output sinhr, rx_nibble,
    input  word_valid, word_data, word_err, frame_done, frame_ok, frame_abort
  );

  modport slave (
    input  sinhr, rx_nibble,
    output word_valid, word_data, word_err, frame_done, frame_ok, frame_abort
  );

endinterface

// File: rtl/uva_nibble_assembler.sv
// ---------------------------------------------------------------------------
// uva_nibble_assembler
// Shifts nibbles MSB-first into a word register and tracks the nibble index.
//   clk_25Mz, rst_n : clock, async active-low reset
//   nib_en          : accept rx_nibble this cycle
//   clr             : rx_nibble is nibble 0 of a new word (frame sync)
//   rx_nibble       : incoming nibble
//   word_full       : this cycle carries the last nibble of a word
//   word_next       : word including this cycle's nibble, valid with word_full
// ---------------------------------------------------------------------------
module uva_nibble_assembler
  import uva_check_pkg::*;
#(
  parameter int WORD_NIBS = 4
) (
  input  logic                         clk_25Mz,
  input  logic                         rst_n,
  input  logic                         nib_en,
  input  logic                         clr,
  input  logic [NIB_W-1:0]             rx_nibble,
  output logic                         word_full,
  output logic [NIB_W*WORD_NIBS-1:0]   word_next
);

  localparam int WORD_W = NIB_W * WORD_NIBS;
  localparam int IDX_W  = (WORD_NIBS > 2) ? $clog2(WORD_NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_NIBS - 1);

  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] word_q;

  assign word_next = {word_q[WORD_W-NIB_W-1:0], rx_nibble};
  // Full is judged on the old index even under clr, so the last nibble of a
  // frame can complete its word while also starting the next frame.
  assign word_full = nib_en && (idx_q == LAST_IDX);

  always_ff @(posedge clk_25Mz or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (nib_en) begin
      if (clr) begin
        idx_q  <= IDX_W'(1);
        word_q <= WORD_W'(rx_nibble);
      end else begin
        idx_q  <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        word_q <= word_next;
      end
    end
  end

endmodule

// File: rtl/uva_nibble_checker.sv
// ---------------------------------------------------------------------------
// uva_nibble_checker
// Reassembles 16-bit words from a nibble stream and checks each frame against
// an incrementing pattern seeded by word 0. Keeps saturating statistics.
//   clk_25Mz, rst_n : nibble clock, async active-low reset
//   clr_cnt         : synchronous clear of word/err/frame counters
//   rx_if (slave)   : sinhr, rx_nibble in; word/frame results out
//   locked          : a frame sync has been seen since reset
//   word_cnt        : checked (non-seed) words, saturating
//   err_cnt         : mismatching words, saturating
//   frame_cnt       : completed frames, saturating
// ---------------------------------------------------------------------------
module uva_nibble_checker
  import uva_check_pkg::*;
#(
  parameter int WORD_NIBS   = 4,
  parameter int FRAME_WORDS = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk_25Mz,
  input  logic              rst_n,
  input  logic              clr_cnt,
  uva_nibble_checker_if.slave rx_if,
  output logic              locked,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);

  // state | meaning
  // IDLE  | waiting for sinhr, nibbles ignored
  // SEED  | collecting word 0, which sets the expected sequence
  // CHECK | collecting words 1..FRAME_WORDS-1, each compared to expected

  localparam int WORD_W = NIB_W * WORD_NIBS;
  localparam int WIDX_W = $clog2(FRAME_WORDS);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(FRAME_WORDS - 1);

  state_t            state_q, state_d;
  logic [WIDX_W-1:0] widx_q;
  logic [WORD_W-1:0] exp_q;
  logic [WORD_W-1:0] word_next;
  logic              word_full;
  logic              nib_en;
  logic              last_word;
  logic              frame_end;
  logic              mid_sync;
  logic              accept;
  logic              cmp_err;
  logic              frame_err_q;

  assign nib_en    = (state_q != IDLE) || rx_if.sinhr;
  assign last_word = (state_q == CHECK) && (widx_q == LAST_WORD);
  assign frame_end = word_full && last_word;
  // A sync landing on the final nibble of a frame is a clean hand-over, not
  // an abort.
  assign mid_sync  = rx_if.sinhr && (state_q != IDLE) && !frame_end;
  assign accept    = word_full && !mid_sync;
  assign cmp_err   = accept && (state_q == CHECK) && (word_next != exp_q);

  uva_nibble_assembler #(.WORD_NIBS(WORD_NIBS)) u_asm (
    .clk_25Mz  (clk_25Mz),
    .rst_n     (rst_n),
    .nib_en    (nib_en),
    .clr       (rx_if.sinhr),
    .rx_nibble (rx_if.rx_nibble),
    .word_full (word_full),
    .word_next (word_next)
  );

  always_ff @(posedge clk_25Mz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_if.sinhr) state_d = SEED;
      SEED:    if (accept) state_d = CHECK;
      CHECK: begin
        if (rx_if.sinhr)    state_d = SEED;
        else if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25Mz or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.word_valid  <= 1'b0;
      rx_if.word_data   <= '0;
      rx_if.word_err    <= 1'b0;
      rx_if.frame_done  <= 1'b0;
      rx_if.frame_ok    <= 1'b0;
      rx_if.frame_abort <= 1'b0;
      locked            <= 1'b0;
      widx_q            <= '0;
      exp_q             <= '0;
      frame_err_q       <= 1'b0;
      word_cnt          <= '0;
      err_cnt           <= '0;
      frame_cnt         <= '0;
    end else begin
      rx_if.word_valid  <= accept;
      rx_if.word_err    <= cmp_err;
      rx_if.frame_done  <= accept && last_word;
      rx_if.frame_ok    <= accept && last_word && !(frame_err_q || cmp_err);
      rx_if.frame_abort <= mid_sync;
      if (accept) rx_if.word_data <= word_next;
      if (rx_if.sinhr) locked <= 1'b1;

      if (rx_if.sinhr) begin
        widx_q <= '0;
      end else if (accept) begin
        widx_q <= (state_q == SEED) ? WIDX_W'(1) :
                  (last_word ? '0 : widx_q + WIDX_W'(1));
      end

      if (accept) begin
        exp_q <= ((state_q == SEED) ? word_next : exp_q) + WORD_W'(1);
      end

      if (rx_if.sinhr)  frame_err_q <= 1'b0;
      else if (cmp_err) frame_err_q <= 1'b1;

      if (clr_cnt) begin
        word_cnt  <= '0;
        err_cnt   <= '0;
        frame_cnt <= '0;
      end else begin
        if (accept && (state_q == CHECK))
          word_cnt <= CNT_W'(sat_inc(32'(word_cnt), CNT_W));
        if (cmp_err)
          err_cnt <= CNT_W'(sat_inc(32'(err_cnt), CNT_W));
        if (accept && last_word)
          frame_cnt <= CNT_W'(sat_inc(32'(frame_cnt), CNT_W));
      end
    end
  end

endmodule

// File: tb/tb_uva_nibble_checker.sv
// ---------------------------------------------------------------------------
// tb_uva_nibble_checker
// Self-checking bench: a frame-level reference model predicts every output
// each cycle; directed scenarios add literal expectations. Counters are built
// 10 bits wide here so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_uva_nibble_checker;
  import uva_check_pkg::*;

  localparam int FW   = 16;
  localparam int CW   = 10;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk_25Mz;
  logic          rst_n;
  logic          clr_cnt;
  logic          locked;
  logic [CW-1:0] word_cnt, err_cnt, frame_cnt;

  uva_nibble_checker_if #(.WORD_W(16)) rx_if ();

  uva_nibble_checker #(.WORD_NIBS(4), .FRAME_WORDS(FW), .CNT_W(CW)) dut (
    .clk_25Mz  (clk_25Mz),
    .rst_n     (rst_n),
    .clr_cnt   (clr_cnt),
    .rx_if     (rx_if),
    .locked    (locked),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt),
    .frame_cnt (frame_cnt)
  );

  initial clk_25Mz = 1'b0;
  always #20 clk_25Mz = ~clk_25Mz;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;
  bit rnd_clr = 0;

  // reference model state
  bit          m_in_frame;
  int          m_pos, m_nibs;
  logic [15:0] m_cur, m_next;
  bit          m_ferr, m_locked;
  int          m_wc, m_ec, m_fc;
  bit          e_valid, e_err, e_done, e_ok, e_abort;
  logic [15:0] e_data;

  // observed pulse tallies for literal checks
  int n_valid = 0, n_err = 0, n_done = 0, n_abort = 0;
  bit last_ok = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_pos = 0; m_nibs = 0; m_cur = '0; m_next = '0;
    m_ferr = 0; m_locked = 0; m_wc = 0; m_ec = 0; m_fc = 0;
    e_valid = 0; e_err = 0; e_done = 0; e_ok = 0; e_abort = 0; e_data = '0;
  endtask

  task automatic start_frame(logic [3:0] n);
    m_in_frame = 1; m_pos = 0; m_nibs = 1; m_cur = {12'h000, n}; m_ferr = 0;
  endtask

  // Outputs expected right after the clock edge that sampled (s, n, c).
  task automatic model_step(bit s, logic [3:0] n, bit c);
    bit completes, last;
    e_valid = 0; e_err = 0; e_done = 0; e_ok = 0; e_abort = 0;
    if (s) m_locked = 1;
    if (m_in_frame) begin
      m_cur = {m_cur[11:0], n};
      m_nibs++;
      completes = (m_nibs == 4);
      last = (m_pos == FW - 1);
      if (s && !(completes && last)) begin
        e_abort = 1;
        start_frame(n);
      end else if (completes) begin
        e_valid = 1;
        e_data = m_cur;
        if (m_pos == 0) begin
          m_next = m_cur + 16'd1;
        end else begin
          e_err = (m_cur != m_next);
          m_next = m_next + 16'd1;
          m_wc = sat(m_wc);
          if (e_err) m_ec = sat(m_ec);
        end
        if (e_err) m_ferr = 1;
        if (last) begin
          e_done = 1;
          e_ok = !m_ferr;
          m_fc = sat(m_fc);
          m_in_frame = 0;
          if (s) start_frame(n);
        end else begin
          m_pos++;
          m_nibs = 0;
        end
      end
    end else if (s) begin
      start_frame(n);
    end
    if (c) begin m_wc = 0; m_ec = 0; m_fc = 0; end
  endtask

  always @(negedge clk_25Mz) begin
    if (check_en) begin
      chk("word_valid", 32'(rx_if.word_valid), 32'(e_valid));
      chk("word_data", 32'(rx_if.word_data), 32'(e_data));
      chk("word_err", 32'(rx_if.word_err), 32'(e_err));
      chk("frame_done", 32'(rx_if.frame_done), 32'(e_done));
      chk("frame_abort", 32'(rx_if.frame_abort), 32'(e_abort));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("word_cnt", 32'(word_cnt), 32'(m_wc));
      chk("err_cnt", 32'(err_cnt), 32'(m_ec));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
      if (e_done) chk("frame_ok", 32'(rx_if.frame_ok), 32'(e_ok));
      if (rx_if.word_valid) n_valid++;
      if (rx_if.word_err) n_err++;
      if (rx_if.frame_abort) n_abort++;
      if (rx_if.frame_done) begin n_done++; last_ok = rx_if.frame_ok; end
    end
  end

  task automatic cyc(bit s, logic [3:0] n, bit c);
    rx_if.sinhr = s; rx_if.rx_nibble = n; clr_cnt = c;
    @(posedge clk_25Mz); #1;
    model_step(s, n, c);
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 4'($urandom), 1'b0);
  endtask

  // bad_pos: -1 clean, -2 every checked word wrong, else that word = bad_val
  function automatic logic [15:0] word_at(logic [15:0] seed, int i, int bad_pos,
                                          logic [15:0] bad_val);
    logic [15:0] w;
    w = seed + 16'(i);
    if (bad_pos == -2 && i > 0) w = w ^ 16'h5A5A;
    else if (bad_pos == i) w = bad_val;
    return w;
  endfunction

  task automatic send_frame(logic [15:0] seed, int bad_pos, logic [15:0] bad_val,
                            int stop_nib, int clr_word);
    logic [15:0] w;
    bit c;
    for (int j = 0; j < stop_nib; j++) begin
      w = word_at(seed, j / 4, bad_pos, bad_val);
      w = w << (4 * (j % 4));
      c = (clr_word == j / 4 && j % 4 == 3) ||
          (rnd_clr && $urandom_range(0, 63) == 0);
      cyc(j == 0, w[15:12], c);
    end
  endtask

  logic [15:0] sa, sb, wv;
  int ab0, fc0;

  initial begin
    rx_if.sinhr = 0; rx_if.rx_nibble = '0; clr_cnt = 0;
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk_25Mz);
    #1;
    check_en = 1;
    chk("rst_word_valid", 32'(rx_if.word_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1;
    idle(3);

    // 1: clean frame seeded 0x1234
    send_frame(16'h1234, -1, '0, FW * 4, -1);
    idle(2);
    chk("t1_valid_pulses", 32'(n_valid), 32'd16);
    chk("t1_done_pulses", 32'(n_done), 32'd1);
    chk("t1_frame_ok", 32'(last_ok), 32'd1);
    chk("t1_word_cnt", 32'(word_cnt), 32'd15);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // 2: word 5 corrupted
    send_frame(16'h1234, 5, 16'hDEAD, FW * 4, -1);
    idle(2);
    chk("t2_err_pulses", 32'(n_err), 32'd1);
    chk("t2_frame_ok", 32'(last_ok), 32'd0);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2_word_cnt", 32'(word_cnt), 32'd30);

    // 3: wrap through 0xFFFF -> 0x0000
    send_frame(16'hFFFE, -1, '0, FW * 4, -1);
    idle(2);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    chk("t3_frame_ok", 32'(last_ok), 32'd1);

    // 4: sinhr after 2 nibbles of word 7
    send_frame(16'h0100, -1, '0, 7 * 4 + 2, -1);
    send_frame(16'h4000, -1, '0, FW * 4, -1);
    idle(2);
    chk("t4_abort_pulses", 32'(n_abort), 32'd1);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd4);
    chk("t4_frame_ok", 32'(last_ok), 32'd1);

    // sinhr on the last nibble of a frame starts the next one
    ab0 = n_abort; fc0 = int'(frame_cnt);
    sa = 16'h5A50;
    send_frame(sa, -1, '0, FW * 4 - 1, -1);
    wv = sa + 16'd15;
    cyc(1'b1, wv[3:0], 1'b0);
    sb = {wv[3:0], 12'h321};
    cyc(1'b0, sb[11:8], 1'b0);
    cyc(1'b0, sb[7:4], 1'b0);
    cyc(1'b0, sb[3:0], 1'b0);
    for (int i = 1; i < FW; i++) begin
      wv = sb + 16'(i);
      for (int k = 0; k < 4; k++) begin
        cyc(1'b0, wv[15:12], 1'b0);
        wv = wv << 4;
      end
    end
    idle(2);
    chk("edge_no_abort", 32'(n_abort - ab0), 32'd0);
    chk("edge_frames", 32'(int'(frame_cnt) - fc0), 32'd2);
    chk("edge_frame_ok", 32'(last_ok), 32'd1);

    // randomized frames, errors, aborts, gaps and counter clears
    rnd_clr = 1;
    for (int f = 0; f < 40; f++) begin
      send_frame(16'($urandom), $urandom_range(0, 1) ? int'($urandom_range(0, FW - 1)) : -1,
                 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FW * 4 - 1)) : FW * 4,
                 -1);
      idle(int'($urandom_range(0, 3)));
    end
    rnd_clr = 0;
    idle(2);

    // 5: saturate err_cnt, then clear coincident with an error
    cyc(1'b0, 4'h0, 1'b1);
    for (int f = 0; f < 69; f++) send_frame(16'($urandom), -2, '0, FW * 4, -1);
    idle(1);
    chk("t5_err_sat", 32'(err_cnt), 32'(MAXC));
    send_frame(16'h0F00, -2, '0, FW * 4, -1);
    idle(1);
    chk("t5_err_hold", 32'(err_cnt), 32'(MAXC));
    send_frame(16'h0F00, -2, '0, FW * 4, FW - 1);
    idle(1);
    chk("t5_err_clr", 32'(err_cnt), 32'd0);
    chk("t5_frame_clr", 32'(frame_cnt), 32'd0);

    // 6: reset pulse during word 3
    send_frame(16'h2222, -1, '0, 3 * 4 + 2, -1);
    rst_n = 0;
    #1;
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_word_data", 32'(rx_if.word_data), 32'd0);
    chk("t6_word_cnt", 32'(word_cnt), 32'd0);
    model_reset();
    @(posedge clk_25Mz); #1;
    rst_n = 1;
    idle(10);
    chk("t6_still_unlocked", 32'(locked), 32'd0);
    fc0 = n_done;
    send_frame(16'hABCD, -1, '0, FW * 4, -1);
    idle(2);
    chk("t6_resume_done", 32'(n_done - fc0), 32'd1);
    chk("t6_resume_ok", 32'(last_ok), 32'd1);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
